parking_gate_sequencer: RTL and testbench
=========================================

# parking_gate_sequencer

Multi-gate successor to the single-gate barrier/display state selector in the parking system. It runs one independent timed barrier sequence per gate and drives each gate's 3-bit display/barrier state. It also keeps a shared lot-occupancy count and rejects entries when the lot is full. It runs on the millisecond tick clock and sits between the debounced gate buttons and the per-gate display/servo drivers.

## Interface
Parameters:
- `NUM_GATES`, default 2: number of gates; each gate can serve entry or exit per request.
- `CNT_W`, default 12: phase counter width.
- `IN_TICKS`, default 2000: length of the ENTRY_OPEN phase, in ms ticks.
- `PAY_TICKS`, default 2000: length of the EXIT_PAY phase.
- `OUT_TICKS`, default 2000: length of the EXIT_OPEN phase.
- `REJ_TICKS`, default 1000: length of the FULL_REJECT phase.
- `CAPACITY`, default 50: number of parking spaces.
- `OCC_W`, default 6: occupancy width; must satisfy 2^OCC_W > CAPACITY.

Ports:
- `ms` in 1: 1 kHz tick clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `press` in NUM_GATES: per-gate request, level. Debounced upstream.
- `is_out` in NUM_GATES: per-gate direction, 1 = exit. Sampled with `press`.
- `state` out 3*NUM_GATES: per-gate state; gate g uses bits [3g+2:3g].
- `occupancy` out OCC_W: committed car count.
- `full` out 1: high when occupancy == CAPACITY.
- `busy` out NUM_GATES: high when the gate's state ≠ IDLE.

## Operation
- State encoding is the same for every gate: 0 IDLE, 1 ENTRY_OPEN, 2 EXIT_PAY, 3 EXIT_OPEN, 4 FULL_REJECT. Codes 5–7 are unused; an illegal code returns the gate to IDLE.
- A request is the rising edge of `press[g]`, detected against a registered copy of `press`. A held level never retriggers.
- A request is accepted only in IDLE. Requests in any other state are ignored; there is no reload or queue.
- IDLE, exit request → EXIT_PAY for PAY_TICKS → EXIT_OPEN for OUT_TICKS → IDLE. Occupancy decrements on the EXIT_OPEN→IDLE transition, saturating at 0.
- IDLE, entry request, with a slot granted → ENTRY_OPEN for IN_TICKS → IDLE. Occupancy increments at acceptance, which reserves the space.
- IDLE, entry request, with no slot granted → FULL_REJECT for REJ_TICKS → IDLE. Occupancy is unchanged.
- Slot grant for same-cycle entry requests:
  - free = CAPACITY − occupancy.
  - Requests are granted in ascending gate index until free is exhausted. The rest get FULL_REJECT.
- The net occupancy update per cycle is granted entries minus completing exits, with a single registered update. An entry and an exit in the same cycle when full: the exit decrement and entry grant are evaluated against the pre-update value, so the entry is rejected.
- Phase counter arithmetic: the counter loads TICKS−1 on phase entry and decrements each tick. The phase ends when the counter reaches 0. Every TICKS parameter must be ≥1 and < 2^CNT_W.

## Timing
- Reset values: `state` = 0 for all gates; `occupancy` = 0; `full` = 0; `busy` = 0. The counters and press history also clear to 0.
- Reset mid-sequence aborts every gate to IDLE. The reservation is lost and occupancy reads 0.
- Latency: with `press` first sampled high at edge k, `state` shows the new phase after edge k (registered, 1-cycle latency).
- Phase durations are exact:
  - ENTRY_OPEN is visible for exactly IN_TICKS edges.
  - EXIT_PAY is visible for exactly PAY_TICKS edges, then EXIT_OPEN for exactly OUT_TICKS.
  - There is no IDLE gap between EXIT_PAY and EXIT_OPEN.
- Back-to-back requests: a rising edge at the edge where the gate returns to IDLE is ignored. The earliest accepted request is one cycle later, and requires a fresh press edge.
- `occupancy` and `full` update at the same edge as the accepting or completing state change.

## Structure
- Shared package `parking_pkg`: state code constants (IDLE, ENTRY_OPEN, EXIT_PAY, EXIT_OPEN, FULL_REJECT) and the state width of 3. These are reused by the display decoder.
- Sub-module `gate_phase_fsm`, instantiated once per gate:
  - Contains the edge detect, phase counter and state register.
  - Inputs: grant, plus the parameters.
  - Outputs: entry_req, exit_done, state.
- The top level holds the priority grant logic, the occupancy register, and `full`.

## Test plan
- Reset, then `press[0]`=1 with `is_out[0]`=0 → state0 = 1 for 2000 ticks, then 0. Occupancy reads 1 from the accepting edge.
- Exit on gate 1 with occupancy 1 → state1 = 2 for 2000 ticks, then 3 for 2000 ticks, then 0. Occupancy 1→0 at the final edge.
- Set CAPACITY=1 with occupancy 0; entry presses on gates 0 and 1 on the same edge → gate0 = 1, gate1 = 4 for 1000 ticks. `full`=1.
- `press` held high for 5000 ticks → exactly one sequence. A re-press during ENTRY_OPEN → ignored, with no duration extension.
- When full, an exit completes on the same edge as an entry request → entry rejected (4). Occupancy drops to CAPACITY−1.
- Exit with occupancy 0 → full sequence runs and occupancy stays 0. `rst_n` pulsed low mid-EXIT_PAY → all states 0 immediately, asynchronously.

Source files
------------

// File: rtl/parking_pkg.sv
// Gate state codes and widths shared by the gate sequencer and the display decoder.
package parking_pkg;

   localparam int unsigned STATE_W = 3;

   typedef logic [STATE_W-1:0] gate_state_t;

   localparam gate_state_t ST_IDLE        = 3'd0;
   localparam gate_state_t ST_ENTRY_OPEN  = 3'd1;
   localparam gate_state_t ST_EXIT_PAY    = 3'd2;
   localparam gate_state_t ST_EXIT_OPEN   = 3'd3;
   localparam gate_state_t ST_FULL_REJECT = 3'd4;

endpackage

// File: rtl/gate_phase_fsm.sv
// One gate's timed barrier sequence: press edge detect, phase counter and state register.
module gate_phase_fsm
   import parking_pkg::*;
#(
   parameter int unsigned CNT_W     = 12,
   parameter int unsigned IN_TICKS  = 2000,
   parameter int unsigned PAY_TICKS = 2000,
   parameter int unsigned OUT_TICKS = 2000,
   parameter int unsigned REJ_TICKS = 1000
) (
   input  logic        ms,
   input  logic        rst_n,
   input  logic        press,
   input  logic        is_out,
   input  logic        grant,
   output logic        entry_req,
   output logic        exit_done,
   output gate_state_t state,
   output logic        busy
);

   logic             press_q;
   logic             rise;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   gate_state_t      state_nxt;

   assign rise      = press & ~press_q;
   assign entry_req = rise & ~is_out & (state == ST_IDLE);
   assign exit_done = (state == ST_EXIT_OPEN) && (cnt == '0);

   // Next phase and counter; each phase lasts TICKS edges from its load of TICKS-1.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (rise) begin
               if (is_out) begin
                  state_nxt = ST_EXIT_PAY;
                  cnt_nxt   = CNT_W'(PAY_TICKS - 1);
               end else if (grant) begin
                  state_nxt = ST_ENTRY_OPEN;
                  cnt_nxt   = CNT_W'(IN_TICKS - 1);
               end else begin
                  state_nxt = ST_FULL_REJECT;
                  cnt_nxt   = CNT_W'(REJ_TICKS - 1);
               end
            end
         end
         ST_ENTRY_OPEN, ST_FULL_REJECT, ST_EXIT_OPEN: begin
            if (cnt == '0) state_nxt = ST_IDLE;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         ST_EXIT_PAY: begin
            if (cnt == '0) begin
               state_nxt = ST_EXIT_OPEN;
               cnt_nxt   = CNT_W'(OUT_TICKS - 1);
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge ms or negedge rst_n) begin
      if (!rst_n) begin
         press_q <= 1'b0;
         state   <= ST_IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
      end else begin
         press_q <= press;
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         busy    <= (state_nxt != ST_IDLE);
      end
   end

endmodule

// File: rtl/parking_gate_sequencer.sv
// Multi-gate barrier sequencer with shared lot occupancy and ascending-index slot grant.
module parking_gate_sequencer
   import parking_pkg::*;
#(
   parameter int unsigned NUM_GATES = 2,
   parameter int unsigned CNT_W     = 12,
   parameter int unsigned IN_TICKS  = 2000,
   parameter int unsigned PAY_TICKS = 2000,
   parameter int unsigned OUT_TICKS = 2000,
   parameter int unsigned REJ_TICKS = 1000,
   parameter int unsigned CAPACITY  = 50,
   parameter int unsigned OCC_W     = 6
) (
   input  logic                         ms,
   input  logic                         rst_n,
   input  logic [NUM_GATES-1:0]         press,
   input  logic [NUM_GATES-1:0]         is_out,
   output logic [STATE_W*NUM_GATES-1:0] state,
   output logic [OCC_W-1:0]             occupancy,
   output logic                         full,
   output logic [NUM_GATES-1:0]         busy
);

   localparam int unsigned SUM_W = OCC_W + 1;

   logic [NUM_GATES-1:0] entry_req;
   logic [NUM_GATES-1:0] exit_done;
   logic [NUM_GATES-1:0] grant;
   logic [SUM_W-1:0]     free;
   logic [SUM_W-1:0]     n_grant;
   logic [SUM_W-1:0]     n_exit;
   logic [SUM_W-1:0]     occ_sum;
   logic [SUM_W-1:0]     occ_nxt;

   for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
      gate_phase_fsm #(
         .CNT_W     (CNT_W),
         .IN_TICKS  (IN_TICKS),
         .PAY_TICKS (PAY_TICKS),
         .OUT_TICKS (OUT_TICKS),
         .REJ_TICKS (REJ_TICKS)
      ) u_fsm (
         .ms        (ms),
         .rst_n     (rst_n),
         .press     (press[g]),
         .is_out    (is_out[g]),
         .grant     (grant[g]),
         .entry_req (entry_req[g]),
         .exit_done (exit_done[g]),
         .state     (state[STATE_W*g +: STATE_W]),
         .busy      (busy[g])
      );
   end

   // Grants and exits both judged against the pre-update count, so a full lot rejects
   // an entry even when an exit completes on the same edge.
   always_comb begin
      grant   = '0;
      n_grant = '0;
      n_exit  = '0;
      free    = SUM_W'(CAPACITY) - {1'b0, occupancy};
      for (int g = 0; g < NUM_GATES; g++) begin
         if (entry_req[g] && (n_grant < free)) begin
            grant[g] = 1'b1;
            n_grant  = n_grant + SUM_W'(1);
         end
         if (exit_done[g]) n_exit = n_exit + SUM_W'(1);
      end
      occ_sum = {1'b0, occupancy} + n_grant;
      occ_nxt = (occ_sum < n_exit) ? '0 : occ_sum - n_exit;
   end

   always_ff @(posedge ms or negedge rst_n) begin
      if (!rst_n) begin
         occupancy <= '0;
         full      <= 1'b0;
      end else begin
         occupancy <= occ_nxt[OCC_W-1:0];
         full      <= (occ_nxt == SUM_W'(CAPACITY));
      end
   end

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Directed bench for the two-gate sequencer with short phases and a two-space lot.
module tb_parking_gate_sequencer;

   localparam int unsigned NG  = 2;
   localparam int unsigned IN  = 6;
   localparam int unsigned PAY = 4;
   localparam int unsigned OUT = 3;
   localparam int unsigned REJ = 2;
   localparam int unsigned CAP = 2;
   localparam int unsigned OW  = 2;

   logic          ms;
   logic          rst_n;
   logic [NG-1:0] press;
   logic [NG-1:0] is_out;
   logic [3*NG-1:0] state;
   logic [OW-1:0] occupancy;
   logic          full;
   logic [NG-1:0] busy;

   int checks = 0;
   int errors = 0;
   int n;

   parking_gate_sequencer #(
      .NUM_GATES (NG), .CNT_W (4), .IN_TICKS (IN), .PAY_TICKS (PAY),
      .OUT_TICKS (OUT), .REJ_TICKS (REJ), .CAPACITY (CAP), .OCC_W (OW)
   ) dut (
      .ms (ms), .rst_n (rst_n), .press (press), .is_out (is_out),
      .state (state), .occupancy (occupancy), .full (full), .busy (busy)
   );

   initial ms = 1'b0;
   always #5 ms = ~ms;

   task automatic tick();
      @(posedge ms);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] st(input int g);
      return state[3*g +: 3];
   endfunction

   // Count edges the gate stays in code, bounded so a stuck gate still ends the run.
   task automatic measure(input int g, input logic [2:0] code, output int cnt);
      cnt = 0;
      while (st(g) == code && cnt < 100) begin
         cnt++;
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0; press = '0; is_out = '0;
      #12;
      chk("rst_state", 32'(state), 32'h0);
      chk("rst_occ", 32'(occupancy), 32'h0);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      tick();

      // entry on gate 0, press held long afterwards
      press = 2'b01; is_out = 2'b00;
      tick();
      chk("entry_state", 32'(state), 32'h01);
      chk("entry_occ", 32'(occupancy), 32'h1);
      chk("entry_busy", 32'(busy), 32'h1);
      chk("entry_full", 32'(full), 32'h0);
      measure(0, 3'd1, n);
      chk("entry_len", 32'(n), 32'(IN));
      chk("entry_done", 32'(state), 32'h0);
      chk("entry_busy_off", 32'(busy), 32'h0);
      repeat (8) tick();
      chk("hold_no_retrig", 32'(state), 32'h0);
      chk("hold_occ", 32'(occupancy), 32'h1);

      // exit on gate 1 with one car in the lot
      press = 2'b00; tick();
      press = 2'b10; is_out = 2'b10;
      tick();
      chk("exit_pay", 32'(state), 32'h10);
      chk("exit_pay_occ", 32'(occupancy), 32'h1);
      measure(1, 3'd2, n);
      chk("pay_len", 32'(n), 32'(PAY));
      chk("exit_open", 32'(st(1)), 32'h3);
      chk("exit_open_occ", 32'(occupancy), 32'h1);
      measure(1, 3'd3, n);
      chk("open_len", 32'(n), 32'(OUT));
      chk("exit_done_state", 32'(state), 32'h0);
      chk("exit_done_occ", 32'(occupancy), 32'h0);

      // one car in, then two simultaneous entries with one space left
      press = 2'b00; is_out = 2'b00; tick();
      press = 2'b01; tick();
      chk("fill1_occ", 32'(occupancy), 32'h1);
      measure(0, 3'd1, n);
      press = 2'b00; tick();
      press = 2'b11; tick();
      chk("grant_state", 32'(state), 32'h21);
      chk("grant_occ", 32'(occupancy), 32'h2);
      chk("grant_full", 32'(full), 32'h1);
      chk("grant_busy", 32'(busy), 32'h3);
      measure(1, 3'd4, n);
      chk("reject_len", 32'(n), 32'(REJ));
      chk("grant_g0_still", 32'(st(0)), 32'h1);
      measure(0, 3'd1, n);
      chk("grant_g0_rest", 32'(n), 32'(IN - REJ));
      chk("grant_occ_after", 32'(occupancy), 32'h2);

      // full lot: exit completes on the same edge as an entry request
      press = 2'b00; tick();
      press = 2'b10; is_out = 2'b10; tick();
      chk("race_exit", 32'(state), 32'h10);
      repeat (6) tick();
      press = 2'b11; tick();
      chk("race_state", 32'(state), 32'h04);
      chk("race_occ", 32'(occupancy), 32'h1);
      chk("race_full", 32'(full), 32'h0);
      measure(0, 3'd4, n);
      chk("race_rej_len", 32'(n), 32'(REJ));

      // re-press during ENTRY_OPEN neither restarts nor extends the phase
      press = 2'b00; is_out = 2'b00; tick();
      press = 2'b01; tick();
      chk("repress_accept", 32'(st(0)), 32'h1);
      chk("repress_full", 32'(full), 32'h1);
      repeat (2) tick();
      press = 2'b00; tick();
      press = 2'b01; tick();
      measure(0, 3'd1, n);
      chk("repress_rest", 32'(n), 32'h2);
      repeat (4) tick();
      chk("repress_idle", 32'(state), 32'h0);
      chk("repress_occ", 32'(occupancy), 32'h2);

      // two exits completing together
      press = 2'b00; tick();
      press = 2'b11; is_out = 2'b11; tick();
      chk("dual_exit", 32'(state), 32'h12);
      repeat (7) tick();
      chk("dual_done", 32'(state), 32'h0);
      chk("dual_occ", 32'(occupancy), 32'h0);
      chk("dual_full", 32'(full), 32'h0);

      // exit with an empty lot saturates at zero
      press = 2'b00; tick();
      press = 2'b01; is_out = 2'b01; tick();
      chk("empty_exit", 32'(state), 32'h02);
      repeat (7) tick();
      chk("empty_done", 32'(state), 32'h0);
      chk("empty_occ", 32'(occupancy), 32'h0);

      // asynchronous reset in the middle of EXIT_PAY
      press = 2'b00; tick();
      press = 2'b11; is_out = 2'b10; tick();
      chk("mix_state", 32'(state), 32'h11);
      chk("mix_occ", 32'(occupancy), 32'h1);
      repeat (2) tick();
      #2;
      rst_n = 1'b0; press = 2'b00;
      #1;
      chk("arst_state", 32'(state), 32'h0);
      chk("arst_occ", 32'(occupancy), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_full", 32'(full), 32'h0);
      #20;
      rst_n = 1'b1;
      tick();
      chk("post_rst_state", 32'(state), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
